// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: issues word fetches, buffers {pc, instr} pairs in a
// small FIFO for decode, and flushes/discards stale responses on control-flow redirects.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr_out,
  output logic [31:0]              instr_pc,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [CW:0]   credits_used;
  logic          req_fire;
  logic          rsp_fire;
  logic          keep;
  logic          pop;
  logic [31:0]   redirect_aligned;

  // Every queued entry and every in-flight request holds one credit, so a kept
  // response always has a free slot waiting for it.
  always_comb begin
    credits_used     = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid   = !reset && !redirect_valid && (credits_used < DEPTH_W);
    req_fire         = imem_req_valid && imem_req_ready;
    rsp_fire         = imem_rsp_valid && (outstanding != '0);
    keep             = rsp_fire && (drop_cnt == '0) && !redirect_valid;
    pop              = instr_valid && instr_ready && !redirect_valid;
    redirect_aligned = {redirect_pc[31:2], 2'b00};
  end

  assign imem_req_addr = fetch_pc;
  assign instr_valid   = (count != '0);
  assign instr_out     = data_mem[head];
  assign instr_pc      = pc_mem[head];
  assign queue_count   = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      pc_mem      <= '{default: '0};
      data_mem    <= '{default: '0};
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
        // Anything still in flight after this edge belongs to the old path;
        // a response landing in this very cycle is dropped by not keeping it.
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        count    <= '0;
        head     <= tail;
        drop_cnt <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (keep) begin
          pc_mem[tail]   <= rsp_pc;
          data_mem[tail] <= imem_rsp_data;
          tail           <= tail + AW'(1);
          rsp_pc         <= rsp_pc + 32'd4;
        end
        if (pop) head <= head + AW'(1);
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: in-order memory model plus an
// epoch-tagged reference of which fetched instructions the core should see.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [CW-1:0] queue_count;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .queue_count(queue_count)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory environment: in-order, one response per cycle, per-request latency.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] acc_log[$];
  int          edge_idx = 0;
  int          lat = 1;
  bit          rand_lat = 1'b0;
  bit          spurious = 1'b0;

  // Reference: each fetch is tagged with the path epoch it was issued on; only
  // responses of the current epoch reach the queue, numbered from the path start.
  logic [31:0] m_fetch = RESET_PC;
  logic [31:0] m_rsp_pc = RESET_PC;
  logic [31:0] m_q[$];
  int          m_flight[$];
  int          m_epoch = 0;
  bit          pe_acc, pe_rsp, pe_pop;
  int          pe_tag;

  function automatic bit m_req_valid();
    return !reset && !redirect_valid && ((m_flight.size() + m_q.size()) < DEPTH);
  endfunction

  task automatic clear_model();
    mem_q.delete();
    acc_log.delete();
    m_q.delete();
    m_flight.delete();
    m_fetch  = RESET_PC;
    m_rsp_pc = RESET_PC;
    m_epoch  = 0;
    imem_rsp_valid = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (spurious) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (!reset && mem_q.size() > 0 && mem_q[0].due <= edge_idx + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Just before each rising edge: let memory capture requests, advance the model.
  initial forever begin
    @(negedge clk);
    #4;
    if (!reset) begin
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{imem_req_addr,
                          edge_idx + 1 + (rand_lat ? int'($urandom_range(1, 4)) : lat)});
        acc_log.push_back(imem_req_addr);
      end
      pe_acc = m_req_valid() && imem_req_ready;
      pe_rsp = imem_rsp_valid && (m_flight.size() > 0);
      pe_pop = (m_q.size() > 0) && instr_ready && !redirect_valid;
      if (pe_pop) void'(m_q.pop_front());
      if (pe_rsp) begin
        pe_tag = m_flight.pop_front();
        if (pe_tag == m_epoch && !redirect_valid) begin
          m_q.push_back(m_rsp_pc);
          m_rsp_pc += 4;
        end
      end
      if (pe_acc) begin
        m_flight.push_back(m_epoch);
        m_fetch += 4;
      end
      if (redirect_valid) begin
        m_q.delete();
        m_epoch++;
        m_fetch  = {redirect_pc[31:2], 2'b00};
        m_rsp_pc = m_fetch;
      end
    end
    edge_idx++;
  end

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    spurious = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    checks += 5;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %h expected 0", instr_out); end
    if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    if (queue_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
  endtask

  task automatic test_fetch();
    lat = 1; rand_lat = 1'b0;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    do_reset();
    #2;
    checks += 2;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL fetch_first_req: got %b expected 1", imem_req_valid); end
    if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL fetch_first_addr: got %h expected %h", imem_req_addr, RESET_PC); end
    @(negedge clk); #2;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid: got %b expected 0", instr_valid); end
    @(negedge clk); #2;
    checks += 3;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_latency: got %b expected 1", instr_valid); end
    if (instr_pc !== RESET_PC) begin errors++; $display("FAIL fetch_first_pc: got %h expected %h", instr_pc, RESET_PC); end
    if (instr_out !== mem_word(RESET_PC)) begin errors++; $display("FAIL fetch_first_data: got %h expected %h", instr_out, mem_word(RESET_PC)); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #2;
      checks += 3;
      if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_stream_valid: got %b expected 1", instr_valid); end
      if (instr_pc !== RESET_PC + 32'(4 * i)) begin errors++; $display("FAIL fetch_stream_pc: got %h expected %h", instr_pc, RESET_PC + 32'(4 * i)); end
      if (instr_out !== mem_word(RESET_PC + 32'(4 * i))) begin errors++; $display("FAIL fetch_stream_data: got %h expected %h", instr_out, mem_word(RESET_PC + 32'(4 * i))); end
    end
  endtask

  task automatic test_consumer_stall();
    lat = 1; rand_lat = 1'b0;
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    #2;
    checks += 2;
    if (queue_count !== CW'(DEPTH)) begin errors++; $display("FAIL stall_full_count: got %0d expected %0d", queue_count, DEPTH); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_blocked: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i)) begin
        errors++; $display("FAIL stall_pop_order: got valid=%b pc=%h expected valid=1 pc=%h", instr_valid, instr_pc, 32'(4 * i));
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (acc_log.size() < 5 || acc_log[4] !== 32'h10) begin
      errors++; $display("FAIL stall_resume_addr: got %h expected 00000010", (acc_log.size() < 5) ? 32'hFFFF_FFFF : acc_log[4]);
    end
  endtask

  task automatic test_mem_stall();
    bit found = 1'b0;
    int n8 = 0;
    lat = 1; rand_lat = 1'b0;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      #2;
      if (imem_req_addr === 32'h8) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL memstall_reach_8: got timeout expected addr 00000008"); end
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      checks += 3;
      if (imem_req_addr !== 32'h8) begin errors++; $display("FAIL memstall_addr_hold: got %h expected 00000008", imem_req_addr); end
      if (imem_req_valid !== m_req_valid()) begin errors++; $display("FAIL memstall_req_valid: got %b expected %b", imem_req_valid, m_req_valid()); end
      if (queue_count !== CW'(m_q.size())) begin errors++; $display("FAIL memstall_count: got %0d expected %0d", queue_count, m_q.size()); end
    end
    imem_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    foreach (acc_log[k]) if (acc_log[k] === 32'h8) n8++;
    checks += 2;
    if (n8 != 1) begin errors++; $display("FAIL memstall_accept_once: got %0d expected 1", n8); end
    if (acc_log.size() < 4 || acc_log[3] !== 32'hC) begin errors++; $display("FAIL memstall_next_addr: got %h expected 0000000c", (acc_log.size() < 4) ? 32'hFFFF_FFFF : acc_log[3]); end
  endtask

  task automatic test_redirect(input logic [31:0] target, input int latency, input int flight);
    bit found = 1'b0;
    logic [31:0] tgt = {target[31:2], 2'b00};
    lat = latency; rand_lat = 1'b0;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (m_flight.size() == flight) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL redirect_setup: got timeout expected %0d in flight", flight); end
    redirect_valid = 1'b1; redirect_pc = target;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    checks += 3;
    if (queue_count !== '0) begin errors++; $display("FAIL redirect_flush: got %0d expected 0", queue_count); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL redirect_valid_low: got %b expected 0", instr_valid); end
    if (imem_req_addr !== tgt) begin errors++; $display("FAIL redirect_addr: got %h expected %h", imem_req_addr, tgt); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (instr_valid === 1'b1) found = 1'b1;
    end
    checks += 2;
    if (!found || instr_pc !== tgt) begin errors++; $display("FAIL redirect_first_pc: got valid=%b pc=%h expected pc=%h", instr_valid, instr_pc, tgt); end
    if (instr_out !== mem_word(tgt)) begin errors++; $display("FAIL redirect_first_data: got %h expected %h", instr_out, mem_word(tgt)); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    lat = 1; rand_lat = 1'b0;
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (m_q.size() == 3 && m_flight.size() == 1) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_setup: got timeout expected 3 queued 1 in flight"); end
    reset = 1'b1;
    clear_model();
    #1;
    checks += 4;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_req_valid: got %b expected 0", imem_req_valid); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_instr_valid: got %b expected 0", instr_valid); end
    if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL rstmid_head: got out=%h pc=%h expected 0", instr_out, instr_pc); end
    if (queue_count !== '0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", queue_count); end
    @(negedge clk);
    instr_ready = 1'b1;
    reset = 1'b0;
    spurious = 1'b1;
    #2;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin errors++; $display("FAIL rstmid_restart: got valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC); end
    @(negedge clk);
    spurious = 1'b0;
    #2;
    checks++;
    if (queue_count !== '0) begin errors++; $display("FAIL rstmid_spurious_ignored: got %0d expected 0", queue_count); end
    @(negedge clk); #2;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr_out !== mem_word(RESET_PC)) begin
      errors++; $display("FAIL rstmid_first_entry: got valid=%b pc=%h out=%h expected pc=%h out=%h", instr_valid, instr_pc, instr_out, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  task automatic test_random();
    rand_lat = 1'b1;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      #2;
      checks += 3;
      if (instr_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_instr_valid: cycle %0d got %b expected %b", c, instr_valid, m_q.size() > 0); end
      if (queue_count !== CW'(m_q.size())) begin errors++; $display("FAIL rand_count: cycle %0d got %0d expected %0d", c, queue_count, m_q.size()); end
      if (imem_req_valid !== m_req_valid()) begin errors++; $display("FAIL rand_req_valid: cycle %0d got %b expected %b", c, imem_req_valid, m_req_valid()); end
      if (m_q.size() > 0) begin
        checks++;
        if (instr_pc !== m_q[0] || instr_out !== mem_word(m_q[0])) begin
          errors++; $display("FAIL rand_head: cycle %0d got pc=%h out=%h expected pc=%h out=%h", c, instr_pc, instr_out, m_q[0], mem_word(m_q[0]));
        end
      end
      if (m_req_valid()) begin
        checks++;
        if (imem_req_addr !== m_fetch) begin errors++; $display("FAIL rand_req_addr: cycle %0d got %h expected %h", c, imem_req_addr, m_fetch); end
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_consumer_stall();
    test_mem_stall();
    test_redirect(32'h0000_0103, 3, 2);
    test_redirect(32'h0000_0200, 1, 1);
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
